// File: rtl/cnn_row_feeder.sv
// ROM row-address sequencer for the first CNN convolution stage: steps through
// IMAGES*ROWS addresses, holding each for DWELL cycles, with a latency-aligned valid strobe.
module cnn_row_feeder #(
   parameter int ADDR_W  = 9,
   parameter int ROWS    = 300,
   parameter int IMAGES  = 1,
   parameter int DWELL   = 26,
   parameter int ROM_LAT = 1,
   parameter int CONT    = 0,
   localparam int IMG_W  = (IMAGES > 1) ? $clog2(IMAGES) : 1
) (
   input  logic              clk,
   input  logic              rst_0,
   input  logic              start,
   input  logic              abort,
   input  logic              hold,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_rden,
   output logic              row_valid,
   output logic              row_first,
   output logic              row_last,
   output logic [IMG_W-1:0]  img_idx,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DWELL - 1);
   localparam logic [CNT_W-1:0]  CNT_LAT   = CNT_W'(ROM_LAT);
   localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
   localparam logic [IMG_W-1:0]  IMG_LAST  = IMG_W'(IMAGES - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMAGES * ROWS - 1);

   if (DWELL < ROM_LAT + 1) begin : g_bad_dwell
      $fatal(1, "cnn_row_feeder: DWELL must be at least ROM_LAT+1");
   end
   if ((longint'(IMAGES) * longint'(ROWS)) > (longint'(1) << ADDR_W)) begin : g_bad_addr_w
      $fatal(1, "cnn_row_feeder: IMAGES*ROWS does not fit in ADDR_W address bits");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [ROW_W-1:0]   row;
   logic [IMG_W-1:0]   img;

   logic               dwell_end;
   logic               row_end;
   logic               img_end;
   logic               run_end;
   logic [CNT_W-1:0]   cnt_nxt;
   logic [ROW_W-1:0]   row_nxt;
   logic [IMG_W-1:0]   img_nxt;
   logic [ADDR_W-1:0]  addr_nxt;
   logic               pulse_nxt;

   assign img_idx = img;

   // Position after one un-held RUN cycle; the end of the last image wraps everything to zero.
   always_comb begin
      dwell_end = (cnt == CNT_LAST);
      row_end   = (row == ROW_LAST);
      img_end   = (img == IMG_LAST);
      run_end   = dwell_end && row_end && img_end;
      cnt_nxt   = dwell_end ? '0 : cnt + 1'b1;
      row_nxt   = row;
      img_nxt   = img;
      addr_nxt  = rom_addr;
      if (run_end) begin
         row_nxt  = '0;
         img_nxt  = '0;
         addr_nxt = '0;
      end else if (dwell_end) begin
         addr_nxt = rom_addr + 1'b1;
         if (row_end) begin
            row_nxt = '0;
            img_nxt = img + 1'b1;
         end else begin
            row_nxt = row + 1'b1;
         end
      end
      pulse_nxt = (cnt_nxt == CNT_LAT);
   end

   // The strobe is registered one edge ahead so it is high exactly while cnt==ROM_LAT.
   always_ff @(posedge clk or negedge rst_0) begin
      if (!rst_0) begin
         state     <= IDLE;
         cnt       <= '0;
         row       <= '0;
         img       <= '0;
         rom_addr  <= '0;
         rom_rden  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         row_valid <= 1'b0;
         row_first <= 1'b0;
         row_last  <= 1'b0;
      end else if (abort) begin
         state     <= IDLE;
         cnt       <= '0;
         row       <= '0;
         img       <= '0;
         rom_addr  <= '0;
         rom_rden  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         row_valid <= 1'b0;
         row_first <= 1'b0;
         row_last  <= 1'b0;
      end else begin
         row_valid <= 1'b0;
         row_first <= 1'b0;
         row_last  <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state     <= RUN;
                  cnt       <= '0;
                  row       <= '0;
                  img       <= '0;
                  rom_addr  <= '0;
                  rom_rden  <= 1'b1;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  row_valid <= (ROM_LAT == 0);
                  row_first <= (ROM_LAT == 0);
                  row_last  <= (ROM_LAT == 0) && (ROWS == 1);
               end
            end
            RUN: begin
               done <= 1'b0;
               if (!hold) begin
                  if (run_end && (CONT == 0)) begin
                     state    <= DONE;
                     cnt      <= '0;
                     rom_rden <= 1'b0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                  end else begin
                     cnt       <= cnt_nxt;
                     row       <= row_nxt;
                     img       <= img_nxt;
                     rom_addr  <= addr_nxt;
                     done      <= run_end;
                     row_valid <= pulse_nxt;
                     row_first <= pulse_nxt && (row_nxt == '0);
                     row_last  <= pulse_nxt && (row_nxt == ROW_LAST);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   a_qual_needs_valid: assert property (@(posedge clk) disable iff (!rst_0)
      (row_first || row_last) |-> row_valid);
   a_valid_needs_busy: assert property (@(posedge clk) disable iff (!rst_0)
      row_valid |-> busy);
   a_addr_in_range: assert property (@(posedge clk) disable iff (!rst_0)
      rom_addr <= ADDR_LAST);
   a_done_busy: assert property (@(posedge clk) disable iff (!rst_0)
      done |-> (busy == (CONT != 0)));

endmodule

// File: tb/tb_cnn_row_feeder.sv
// Scoreboard bench for cnn_row_feeder: one single-run and one continuous instance,
// expected pulses derived from a progress count of un-held RUN cycles.
module tb_cnn_row_feeder;

   localparam int ADDR_W  = 9;
   localparam int ROWS    = 4;
   localparam int IMAGES  = 2;
   localparam int DWELL   = 3;
   localparam int ROM_LAT = 1;
   localparam int IMG_W   = 1;
   localparam int TOTAL   = ROWS * IMAGES;
   localparam int FRAME   = TOTAL * DWELL;

   logic              clk = 1'b0;
   logic              rst_0;
   logic              start     [2];
   logic              abort     [2];
   logic              hold      [2];
   logic [ADDR_W-1:0] rom_addr  [2];
   logic              rom_rden  [2];
   logic              row_valid [2];
   logic              row_first [2];
   logic              row_last  [2];
   logic [IMG_W-1:0]  img_idx   [2];
   logic              busy      [2];
   logic              done      [2];

   cnn_row_feeder #(.ADDR_W(ADDR_W), .ROWS(ROWS), .IMAGES(IMAGES), .DWELL(DWELL),
                    .ROM_LAT(ROM_LAT), .CONT(0)) dut0 (
      .clk(clk), .rst_0(rst_0), .start(start[0]), .abort(abort[0]), .hold(hold[0]),
      .rom_addr(rom_addr[0]), .rom_rden(rom_rden[0]), .row_valid(row_valid[0]),
      .row_first(row_first[0]), .row_last(row_last[0]), .img_idx(img_idx[0]),
      .busy(busy[0]), .done(done[0]));

   cnn_row_feeder #(.ADDR_W(ADDR_W), .ROWS(ROWS), .IMAGES(IMAGES), .DWELL(DWELL),
                    .ROM_LAT(ROM_LAT), .CONT(1)) dut1 (
      .clk(clk), .rst_0(rst_0), .start(start[1]), .abort(abort[1]), .hold(hold[1]),
      .rom_addr(rom_addr[1]), .rom_rden(rom_rden[1]), .row_valid(row_valid[1]),
      .row_first(row_first[1]), .row_last(row_last[1]), .img_idx(img_idx[1]),
      .busy(busy[1]), .done(done[1]));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int fails  = 0;

   typedef struct {
      int inst;
      int stamp;
      int addr;
      bit first;
      bit last;
      int img;
   } pulse_t;

   typedef struct {
      int inst;
      int stamp;
   } done_t;

   pulse_t pulseQ[$];
   done_t  doneQ[$];
   pulse_t e;
   done_t  d;
   bit     prevDone [2] = '{1'b0, 1'b0};

   // Monitor: every expectation carries the negedge cycle at which it must be visible.
   always @(negedge clk) begin
      while (pulseQ.size() > 0 && pulseQ[0].stamp < cyc) begin
         checks++; fails++;
         $display("[TB] FAIL missedPulse inst=%0d addr=%0d: no row_valid seen, required at cycle %0d",
                  pulseQ[0].inst, pulseQ[0].addr, pulseQ[0].stamp);
         void'(pulseQ.pop_front());
      end
      while (doneQ.size() > 0 && doneQ[0].stamp < cyc) begin
         checks++; fails++;
         $display("[TB] FAIL missedDone inst=%0d: no done rise seen, required at cycle %0d",
                  doneQ[0].inst, doneQ[0].stamp);
         void'(doneQ.pop_front());
      end
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (rom_rden[k] !== busy[k]) begin
            fails++;
            $display("[TB] FAIL rdenBusy inst=%0d cycle=%0d rom_rden=%b, required equal to busy=%b",
                     k, cyc, rom_rden[k], busy[k]);
         end
         checks++;
         if ((row_first[k] === 1'b1 || row_last[k] === 1'b1) && row_valid[k] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL qualNoValid inst=%0d cycle=%0d first=%b last=%b valid=%b, required 0 0 when valid low",
                     k, cyc, row_first[k], row_last[k], row_valid[k]);
         end
         if (row_valid[k] === 1'b1) begin
            checks++;
            if (pulseQ.size() == 0 || pulseQ[0].inst != k || pulseQ[0].stamp != cyc) begin
               fails++;
               $display("[TB] FAIL unexpectedPulse inst=%0d cycle=%0d addr=%0d, required no row_valid here",
                        k, cyc, rom_addr[k]);
            end else begin
               e = pulseQ.pop_front();
               if ({rom_addr[k], row_first[k], row_last[k], img_idx[k]} !==
                   {ADDR_W'(e.addr), e.first, e.last, IMG_W'(e.img)}) begin
                  fails++;
                  $display("[TB] FAIL pulseFields inst=%0d cycle=%0d got addr=%0d first=%b last=%b img=%0d, required addr=%0d first=%b last=%b img=%0d",
                           k, cyc, rom_addr[k], row_first[k], row_last[k], img_idx[k],
                           e.addr, e.first, e.last, e.img);
               end
            end
         end
         if (done[k] === 1'b1 && !prevDone[k]) begin
            checks++;
            if (doneQ.size() == 0 || doneQ[0].inst != k || doneQ[0].stamp != cyc) begin
               fails++;
               $display("[TB] FAIL unexpectedDone inst=%0d cycle=%0d done=1, required 0", k, cyc);
            end else begin
               d = doneQ.pop_front();
            end
            if (k == 1) begin
               checks++;
               if (busy[1] !== 1'b1) begin
                  fails++;
                  $display("[TB] FAIL contBusy cycle=%0d busy=%b, required 1 during done pulse", cyc, busy[1]);
               end
            end
         end
         if (k == 1 && done[1] === 1'b1 && prevDone[1]) begin
            checks++; fails++;
            $display("[TB] FAIL doneWidth cycle=%0d done high 2 cycles, required 1-cycle pulse", cyc);
         end
         prevDone[k] = (done[k] === 1'b1);
      end
   end

   task automatic checkZero(input string tag);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if ({rom_addr[k], rom_rden[k], row_valid[k], row_first[k], row_last[k],
              img_idx[k], busy[k], done[k]} !== '0) begin
            fails++;
            $display("[TB] FAIL %s inst=%0d addr=%0d rden=%b valid=%b first=%b last=%b img=%0d busy=%b done=%b, required all 0",
                     tag, k, rom_addr[k], rom_rden[k], row_valid[k], row_first[k], row_last[k],
                     img_idx[k], busy[k], done[k]);
         end
      end
   endtask

   task automatic checkOutput(input string tag);
      checks++;
      if ({done[0], busy[0], rom_rden[0], rom_addr[0]} !== {1'b1, 1'b0, 1'b0, ADDR_W'(TOTAL - 1)}) begin
         fails++;
         $display("[TB] FAIL %s done=%b busy=%b rden=%b addr=%0d, required done=1 busy=0 rden=0 addr=%0d",
                  tag, done[0], busy[0], rom_rden[0], rom_addr[0], TOTAL - 1);
      end
   endtask

   // Called at a negedge; raises start now and then walks stopP un-held cycles.
   task automatic applyStimulus(input int k, input int holdPct, input int stopP,
                                input int holdAt, input int holdLen);
      int p        = 0;
      int holdLeft = holdLen;
      int guard    = 0;
      int r;
      start[k] = 1'b1;
      hold[k]  = 1'b0;
      abort[k] = 1'b0;
      while (p < stopP && guard < 5000) begin
         @(negedge clk);
         guard++;
         start[k] = 1'b0;
         if (p == holdAt && holdLeft > 0) begin
            hold[k] = 1'b1;
            holdLeft--;
         end else begin
            hold[k] = ($urandom_range(99) < holdPct);
         end
         if (!hold[k]) begin
            p++;
            if (p % DWELL == ROM_LAT && (k == 1 || p < FRAME)) begin
               r = (p / DWELL) % TOTAL;
               pulseQ.push_back('{k, cyc + 1, r, (r % ROWS) == 0, (r % ROWS) == ROWS - 1, r / ROWS});
            end
            if (p % FRAME == 0) doneQ.push_back('{k, cyc + 1});
         end
      end
      if (guard >= 5000) begin
         checks++; fails++;
         $display("[TB] FAIL stimulusTimeout inst=%0d progress=%0d, required %0d", k, p, stopP);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      for (int k = 0; k < 2; k++) begin
         start[k] = 1'b0;
         abort[k] = 1'b0;
         hold[k]  = 1'b0;
      end
      rst_0 = 1'b1;
      #1 rst_0 = 1'b0;
      #2 checkZero("resetAsync");
      @(negedge clk);
      @(negedge clk);
      rst_0 = 1'b1;
      repeat (20) begin
         @(negedge clk);
         checkZero("idleNoStart");
      end

      @(negedge clk);
      applyStimulus(0, 0, FRAME, -1, 0);
      @(negedge clk);
      checkOutput("singleRunDone");
      repeat (4) @(negedge clk);
      checkOutput("doneHeld");

      applyStimulus(0, 0, FRAME, 2 * DWELL + 1, 5);
      @(negedge clk);
      checkOutput("holdRunDone");

      repeat (3) begin
         applyStimulus(0, 30, FRAME, -1, 0);
         @(negedge clk);
         hold[0] = 1'b0;
         checkOutput("randomHoldDone");
      end

      abort[0] = 1'b1;
      @(negedge clk);
      abort[0] = 1'b0;
      checkZero("abortFromDone");

      applyStimulus(0, 20, 5 * DWELL + 1, -1, 0);
      @(negedge clk);
      hold[0]  = 1'b0;
      abort[0] = 1'b1;
      start[0] = 1'b1;
      @(negedge clk);
      abort[0] = 1'b0;
      start[0] = 1'b0;
      checkZero("abortWithStart");
      repeat (6) @(negedge clk);
      checkZero("idleAfterAbort");

      applyStimulus(0, 0, FRAME, -1, 0);
      @(negedge clk);
      checkOutput("restartAfterAbort");

      applyStimulus(0, 0, 3 * DWELL + 1, -1, 0);
      @(negedge clk);
      #2 rst_0 = 1'b0;
      #1 checkZero("resetMidRun");
      @(negedge clk);
      rst_0 = 1'b1;
      applyStimulus(0, 0, FRAME, -1, 0);
      @(negedge clk);
      checkOutput("runAfterReset");

      applyStimulus(1, 25, 3 * FRAME, -1, 0);
      @(negedge clk);
      hold[1]  = 1'b0;
      abort[1] = 1'b1;
      @(negedge clk);
      abort[1] = 1'b0;
      abort[0] = 1'b1;
      @(negedge clk);
      abort[0] = 1'b0;
      checkZero("contAborted");

      repeat (3) @(negedge clk);
      checks++;
      if (pulseQ.size() != 0) begin
         fails++;
         $display("[TB] FAIL pulseQueueDrained left=%0d, required 0", pulseQ.size());
      end
      checks++;
      if (doneQ.size() != 0) begin
         fails++;
         $display("[TB] FAIL doneQueueDrained left=%0d, required 0", doneQ.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
